// File: rtl/core_pkg.sv
// Core-wide datapath widths shared by every pipeline stage.
package core_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
endpackage

// File: rtl/wb_pkg.sv
// Writeback-stage control types and the MEM->WB payload layout.
package wb_pkg;
  import core_pkg::*;

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    GPR_IDLE = 2'd0,
    GPR_EXE,
    GPR_OP3,
    GPR_MEM
  } gpr_ctrl_t;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
  } csr_ctrl_t;

  typedef enum logic [3:0] {
    MEM_IDLE = 4'd0,
    LB, LBU, LH, LHU, LW, LWU, LD,
    SB, SH, SW, SD
  } mem_ctrl_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] exe_out;
    logic [DATA_WIDTH-1:0] op3;
    logic [4:0]            rd;
    gpr_ctrl_t             gpr_ctrl;
    csr_ctrl_t             csr_ctrl;
    mem_ctrl_t             mem_ctrl;
  } mem2wb_t;

  typedef enum logic [0:0] {
    WB_RUN  = 1'b0,
    WB_HOLD = 1'b1
  } wb_state_t;
endpackage

// File: rtl/writeback_load_ext.sv
// Load data alignment and sign/zero extension; purely combinational.
module load_ext
  import core_pkg::*;
  import wb_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [OFF_W-1:0]      offset_i,
  input  logic [3:0]            mem_ctrl_i,
  output logic [DATA_WIDTH-1:0] wdata_o
);

  logic [DATA_WIDTH-1:0] shifted;
  mem_ctrl_t             op;

  // Keep the low 'bits' bits, fill the rest with the top kept bit or zeros.
  function automatic logic [DATA_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] v,
                                                input int bits, input logic sgn);
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] top;
    logic                  fill;
    mask = ~({DATA_WIDTH{1'b1}} << bits);
    top  = v >> (bits - 1);
    fill = sgn & top[0];
    return (v & mask) | ({DATA_WIDTH{fill}} & ~mask);
  endfunction

  always_comb begin
    op      = mem_ctrl_t'(mem_ctrl_i);
    shifted = rdata_i >> {offset_i, 3'b000};
    wdata_o = '0;
    case (op)
      LB:      wdata_o = ext(shifted, 8, 1'b1);
      LBU:     wdata_o = ext(shifted, 8, 1'b0);
      LH:      wdata_o = ext(shifted, 16, 1'b1);
      LHU:     wdata_o = ext(shifted, 16, 1'b0);
      LW:      wdata_o = ext(shifted, 32, 1'b1);
      LWU:     wdata_o = (DATA_WIDTH == 64) ? ext(shifted, 32, 1'b0) : '0;
      LD:      wdata_o = (DATA_WIDTH == 64) ? shifted : '0;
      default: wdata_o = '0;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: commits GPR/CSR writes atomically, stalls on CSR backpressure,
// and counts retired instructions.
module writeback
  import core_pkg::*;
  import wb_pkg::*;
#(
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     mem_valid_i,
  output logic                     ready_o,
  input  mem2wb_t                  mem2wb_i,
  input  logic [DATA_WIDTH-1:0]    d_m_rdata_i,
  input  logic                     csr_ready_i,
  output logic                     gpr_wren_o,
  output logic [4:0]               gpr_waddr_o,
  output logic [DATA_WIDTH-1:0]    gpr_wdata_o,
  output logic                     csr_wren_o,
  output logic [11:0]              csr_waddr_o,
  output logic [DATA_WIDTH-1:0]    csr_wdata_o,
  output logic                     retire_o,
  output logic [INSTRET_WIDTH-1:0] instret_o
);

  logic                     valid_q;
  mem2wb_t                  payload_q;
  wb_state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0]    hold_q, hold_d;
  logic [INSTRET_WIDTH-1:0] instret_q;
  logic                     commit;
  logic [DATA_WIDTH-1:0]    load_src;
  logic [DATA_WIDTH-1:0]    load_data;

  assign commit  = valid_q && (!payload_q.csr_ctrl.wr || csr_ready_i);
  assign ready_o = !valid_q || commit;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (ready_o) begin
      valid_q <= mem_valid_i;
      if (mem_valid_i) payload_q <= mem2wb_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= WB_RUN;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Read data is only present for one cycle, so it is parked while the CSR file stalls.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      WB_RUN: begin
        if (valid_q && payload_q.csr_ctrl.wr && !csr_ready_i) begin
          state_d = WB_HOLD;
          hold_d  = d_m_rdata_i;
        end
      end
      WB_HOLD: begin
        if (csr_ready_i) state_d = WB_RUN;
      end
      default: state_d = WB_RUN;
    endcase
  end

  assign load_src = (state_q == WB_HOLD) ? hold_q : d_m_rdata_i;

  load_ext u_load_ext (
    .rdata_i    (load_src),
    .offset_i   (payload_q.exe_out[OFF_W-1:0]),
    .mem_ctrl_i (payload_q.mem_ctrl),
    .wdata_o    (load_data)
  );

  always_comb begin
    gpr_wdata_o = '0;
    case (payload_q.gpr_ctrl)
      GPR_EXE: gpr_wdata_o = payload_q.exe_out;
      GPR_OP3: gpr_wdata_o = payload_q.op3;
      GPR_MEM: gpr_wdata_o = load_data;
      default: gpr_wdata_o = '0;
    endcase
  end

  assign gpr_wren_o  = commit && (payload_q.gpr_ctrl != GPR_IDLE) && (payload_q.rd != 5'd0);
  assign gpr_waddr_o = payload_q.rd;
  assign csr_wren_o  = commit && payload_q.csr_ctrl.wr;
  assign csr_waddr_o = payload_q.csr_ctrl.addr;
  assign csr_wdata_o = payload_q.exe_out;
  assign retire_o    = commit;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) instret_q <= '0;
    else if (commit) instret_q <= instret_q + INSTRET_WIDTH'(1);
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_writeback.sv
// Directed vector bench for the writeback stage.
module tb_writeback;
  import core_pkg::*;
  import wb_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rstn_i;
  logic                  mem_valid_i;
  logic                  ready_o;
  mem2wb_t               mem2wb_i;
  logic [DATA_WIDTH-1:0] d_m_rdata_i;
  logic                  csr_ready_i;
  logic                  gpr_wren_o;
  logic [4:0]            gpr_waddr_o;
  logic [DATA_WIDTH-1:0] gpr_wdata_o;
  logic                  csr_wren_o;
  logic [11:0]           csr_waddr_o;
  logic [DATA_WIDTH-1:0] csr_wdata_o;
  logic                  retire_o;
  logic [63:0]           instret_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_instret = 64'd0;

  writeback #(.INSTRET_WIDTH(64)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .mem_valid_i(mem_valid_i), .ready_o(ready_o),
    .mem2wb_i(mem2wb_i), .d_m_rdata_i(d_m_rdata_i), .csr_ready_i(csr_ready_i),
    .gpr_wren_o(gpr_wren_o), .gpr_waddr_o(gpr_waddr_o), .gpr_wdata_o(gpr_wdata_o),
    .csr_wren_o(csr_wren_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .retire_o(retire_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] exe;
    logic [31:0] op3;
    logic [4:0]  rd;
    gpr_ctrl_t   g;
    mem_ctrl_t   m;
    logic [31:0] rdata;
    logic        exp_wren;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic mem2wb_t mk(input logic [31:0] exe, input logic [31:0] op3,
                                 input logic [4:0] rd, input gpr_ctrl_t g,
                                 input mem_ctrl_t m, input logic wr, input logic [11:0] addr);
    mem2wb_t p;
    p = '0;
    p.exe_out = exe; p.op3 = op3; p.rd = rd; p.gpr_ctrl = g; p.mem_ctrl = m;
    p.csr_ctrl.wr = wr; p.csr_ctrl.addr = addr;
    return p;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem2wb_i    = mk(v.exe, v.op3, v.rd, v.g, v.m, 1'b0, 12'h0);
    csr_ready_i = 1'b1;
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    d_m_rdata_i = v.rdata;
    #1;
    check({tag, "_wren"}, 64'(gpr_wren_o), 64'(v.exp_wren));
    if (v.exp_wren) begin
      check({tag, "_waddr"}, 64'(gpr_waddr_o), 64'(v.rd));
      check({tag, "_wdata"}, 64'(gpr_wdata_o), 64'(v.exp_wdata));
    end
    check({tag, "_csr_wren"}, 64'(csr_wren_o), 64'd0);
    check({tag, "_retire"}, 64'(retire_o), 64'd1);
    @(posedge clk_i);
    #1;
    exp_instret++;
    check({tag, "_instret"}, instret_o, exp_instret);
  endtask

  initial begin
    vecs[0]  = '{32'h1234, 32'h0, 5'd5, GPR_EXE, MEM_IDLE, 32'h0,          1'b1, 32'h0000_1234};
    vecs[1]  = '{32'h2,    32'h0, 5'd6, GPR_MEM, LB,       32'h0080_0000,  1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{32'h2,    32'h0, 5'd6, GPR_MEM, LBU,      32'h0080_0000,  1'b1, 32'h0000_0080};
    vecs[3]  = '{32'h2,    32'h0, 5'd7, GPR_MEM, LH,       32'h8001_0000,  1'b1, 32'hFFFF_8001};
    vecs[4]  = '{32'h2,    32'h0, 5'd7, GPR_MEM, LHU,      32'h8001_0000,  1'b1, 32'h0000_8001};
    vecs[5]  = '{32'h0,    32'h0, 5'd8, GPR_MEM, LW,       32'hDEAD_BEEF,  1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{32'h3,    32'h0, 5'd9, GPR_MEM, LB,       32'h7F00_0000,  1'b1, 32'h0000_007F};
    vecs[7]  = '{32'h1,    32'h0, 5'd10, GPR_MEM, LB,      32'h0000_FF00,  1'b1, 32'hFFFF_FFFF};
    vecs[8]  = '{32'h9,    32'h44, 5'd1, GPR_OP3, MEM_IDLE, 32'h0,         1'b1, 32'h0000_0044};
    vecs[9]  = '{32'h77,   32'h0, 5'd0, GPR_EXE, MEM_IDLE, 32'h0,          1'b0, 32'h0};
    vecs[10] = '{32'h77,   32'h0, 5'd7, GPR_IDLE, MEM_IDLE, 32'h0,         1'b0, 32'h0};

    rstn_i = 1'b0; mem_valid_i = 1'b0; mem2wb_i = '0; d_m_rdata_i = '0; csr_ready_i = 1'b1;
    #2;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_gpr_wren", 64'(gpr_wren_o), 64'd0);
    check("rst_csr_wren", 64'(csr_wren_o), 64'd0);
    check("rst_retire", 64'(retire_o), 64'd0);
    check("rst_instret", instret_o, 64'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Bubbles: nothing written, nothing retired.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      mem_valid_i = 1'b0;
      #1;
      check($sformatf("bubble%0d_wren", k), 64'(gpr_wren_o), 64'd0);
      check($sformatf("bubble%0d_retire", k), 64'(retire_o), 64'd0);
      @(posedge clk_i);
      #1;
      check($sformatf("bubble%0d_instret", k), instret_o, exp_instret);
    end

    // CSR stall: csrrw held for three cycles while a younger op waits.
    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem2wb_i    = mk(32'hB, 32'hA, 5'd3, GPR_OP3, MEM_IDLE, 1'b1, 12'h300);
    csr_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      mem_valid_i = 1'b1;
      mem2wb_i    = mk(32'h55, 32'h0, 5'd9, GPR_EXE, MEM_IDLE, 1'b0, 12'h0);
      csr_ready_i = 1'b0;
      #1;
      check($sformatf("stall%0d_ready", k), 64'(ready_o), 64'd0);
      check($sformatf("stall%0d_gpr_wren", k), 64'(gpr_wren_o), 64'd0);
      check($sformatf("stall%0d_csr_wren", k), 64'(csr_wren_o), 64'd0);
      check($sformatf("stall%0d_retire", k), 64'(retire_o), 64'd0);
    end
    @(negedge clk_i);
    csr_ready_i = 1'b1;
    #1;
    check("csrrw_gpr_wren", 64'(gpr_wren_o), 64'd1);
    check("csrrw_gpr_waddr", 64'(gpr_waddr_o), 64'd3);
    check("csrrw_gpr_wdata", 64'(gpr_wdata_o), 64'hA);
    check("csrrw_csr_wren", 64'(csr_wren_o), 64'd1);
    check("csrrw_csr_waddr", 64'(csr_waddr_o), 64'h300);
    check("csrrw_csr_wdata", 64'(csr_wdata_o), 64'hB);
    check("csrrw_ready", 64'(ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    exp_instret++;
    check("csrrw_instret", instret_o, exp_instret);
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    #1;
    check("after_stall_wren", 64'(gpr_wren_o), 64'd1);
    check("after_stall_waddr", 64'(gpr_waddr_o), 64'd9);
    check("after_stall_wdata", 64'(gpr_wdata_o), 64'h55);
    check("after_stall_csr_wren", 64'(csr_wren_o), 64'd0);
    @(posedge clk_i);
    #1;
    exp_instret++;
    check("after_stall_instret", instret_o, exp_instret);

    // Load with CSR write: read data only valid in the first cycle.
    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem2wb_i    = mk(32'h0, 32'h0, 5'd4, GPR_MEM, LW, 1'b1, 12'h341);
    csr_ready_i = 1'b1;
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    d_m_rdata_i = 32'hDEAD_BEEF;
    csr_ready_i = 1'b0;
    #1;
    check("ldstall0_wren", 64'(gpr_wren_o), 64'd0);
    @(negedge clk_i);
    d_m_rdata_i = 32'h0;
    #1;
    check("ldstall1_retire", 64'(retire_o), 64'd0);
    @(negedge clk_i);
    csr_ready_i = 1'b1;
    #1;
    check("ldstall_gpr_wren", 64'(gpr_wren_o), 64'd1);
    check("ldstall_gpr_wdata", 64'(gpr_wdata_o), 64'hDEAD_BEEF);
    check("ldstall_csr_wren", 64'(csr_wren_o), 64'd1);
    check("ldstall_csr_waddr", 64'(csr_waddr_o), 64'h341);
    @(posedge clk_i);
    #1;
    exp_instret++;
    check("ldstall_instret", instret_o, exp_instret);

    // Asynchronous reset while a CSR write is stalled.
    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem2wb_i    = mk(32'hC, 32'hD, 5'd2, GPR_OP3, MEM_IDLE, 1'b1, 12'h305);
    csr_ready_i = 1'b1;
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    csr_ready_i = 1'b0;
    d_m_rdata_i = 32'h1111_1111;
    @(posedge clk_i);
    #2;
    check("prerst_ready", 64'(ready_o), 64'd0);
    rstn_i = 1'b0;
    #1;
    csr_ready_i = 1'b1;
    #0;
    check("arst_gpr_wren", 64'(gpr_wren_o), 64'd0);
    check("arst_csr_wren", 64'(csr_wren_o), 64'd0);
    check("arst_retire", 64'(retire_o), 64'd0);
    check("arst_instret", instret_o, 64'd0);
    check("arst_ready", 64'(ready_o), 64'd1);
    exp_instret = 64'd0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    check("postrst_ready", 64'(ready_o), 64'd1);
    run_vec(vecs[1], "postrst_lb");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Final pipeline stage of the SCHOLAR RISC-V core. Sits directly downstream of the MEM stage and consumes the MEM->WB payload plus the data-memory read data.
- Performs load-data byte extraction and sign/zero extension.
- Commits results atomically to the GPR file and the CSR file.
- Applies backpressure when the CSR file stalls, and counts retired instructions.

Parameters:
- INSTRET_WIDTH, 64, width of the retired-instruction counter (instret_o).
- DATA_WIDTH and ADDR_WIDTH come from core_pkg (32 or 64); they are not local parameters.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  system reset; asynchronous assertion, active-low
- mem_valid_i  in  1  MEM stage payload/transaction valid
- ready_o  out  1  WB can accept a new MEM->WB payload this cycle
- mem2wb_i  in  mem2wb_t  payload: exe_out, op3, rd, gpr_ctrl, csr_ctrl, mem_ctrl
- d_m_rdata_i  in  DATA_WIDTH  data-memory read data, valid the cycle after MEM issued the read
- csr_ready_i  in  1  CSR file can accept a write this cycle
- gpr_wren_o  out  1  GPR write enable
- gpr_waddr_o  out  5  GPR write address
- gpr_wdata_o  out  DATA_WIDTH  GPR write data
- csr_wren_o  out  1  CSR write enable
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  DATA_WIDTH  CSR write data
- retire_o  out  1  one-cycle pulse per committed non-bubble instruction
- instret_o  out  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Payload register:
  - Captures mem2wb_i and sets valid_q=1 on a clock edge where mem_valid_i && ready_o.
  - If ready_o=1 and mem_valid_i=0, clears valid_q (bubble); payload contents are don't-care.
  - If ready_o=0, holds.
- Reset (async, rstn_i=0): valid_q=0, state=RUN, hold_q=0, instret_o=0. All write enables and retire_o go to 0 immediately. ready_o=1 and remains 1 after release. An in-flight instruction is dropped without retiring.
- FSM states:
  - RUN: load data source is d_m_rdata_i.
  - HOLD: load data source is hold_q.
- FSM transitions:
  - RUN->HOLD when valid_q && csr_ctrl.wr && !csr_ready_i. On that edge, d_m_rdata_i is latched into hold_q.
  - HOLD->RUN when csr_ready_i=1 (the commit cycle).
  - Otherwise stay in RUN.
- commit = valid_q && (!csr_ctrl.wr || csr_ready_i).
- ready_o = !valid_q || commit (combinational). A new payload may be captured in the commit cycle.
- GPR write data select (gpr_ctrl):
  - GPR_IDLE: no write.
  - GPR_EXE: write exe_out.
  - GPR_OP3: write op3 (old CSR value, or PC+4 for link).
  - GPR_MEM: write extracted load data.
- Load extraction:
  - Byte offset = exe_out[$clog2(DATA_WIDTH/8)-1:0]. The source word is shifted right by offset*8.
  - mem_ctrl selects LB/LBU/LH/LHU/LW/LWU/LD with sign or zero extension. LWU and LD exist only when DATA_WIDTH=64.
  - Misaligned accesses never reach WB; MEM guarantees alignment.
- GPR write port:
  - gpr_wren_o = commit && gpr_ctrl!=GPR_IDLE && rd!=0.
  - gpr_waddr_o = rd.
- CSR write port:
  - csr_wren_o = commit && csr_ctrl.wr.
  - csr_waddr_o = csr_ctrl.addr.
  - csr_wdata_o = exe_out.
- Atomicity: GPR and CSR writes of one instruction occur in the same cycle. No partial commit occurs during a stall.
- Retire: retire_o = commit. instret_o increments by 1 on each commit edge and wraps modulo 2^INSTRET_WIDTH.
- Latency: capture edge -> commit in the following cycle, when csr_ready_i=1.

Decomposition:
- Package wb_pkg:
  - gpr_ctrl_t enum {GPR_IDLE=0, GPR_EXE, GPR_OP3, GPR_MEM}.
  - csr_ctrl_t packed struct {wr, addr[11:0]}; all-zero means idle.
  - mem_ctrl_t enum {MEM_IDLE=0, LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD}.
- mem2wb_pkg references these types.
- Sub-module load_ext: purely combinational extraction/extension (rdata, offset, mem_ctrl -> wdata). Instantiated once.

Test Plan:
- ALU op: capture exe_out=0x1234, rd=5, GPR_EXE, csr_ready_i=1 -> next cycle gpr_wren_o=1, waddr=5, wdata=0x1234, retire_o=1, instret_o=1 after the edge.
- LB sign extension: exe_out low bits=2, rdata=0x0080_0000, mem_ctrl=LB -> wdata=0xFFFF_FF80 (XLEN sign-extended). Same stimulus with LBU -> 0x80.
- CSR stall: csrrw with csr_ctrl={1,0x300}, op3=0xA, exe_out=0xB, csr_ready_i=0 for 3 cycles:
  - During the stall: ready_o=0, no writes, retire_o=0.
  - Next capture is blocked for the whole stall.
  - On the 4th cycle (csr_ready_i=1): gpr wdata=0xA and csr wdata=0xB in the same cycle.
- Load during CSR stall: LW with csr write, rdata=0xDEADBEEF present only in the first cycle and 0 afterwards -> commit writes 0xDEADBEEF via hold_q.
- rd=0 and bubbles: GPR_EXE with rd=0 -> gpr_wren_o=0, retire_o=1. mem_valid_i=0 -> no write, no retire.
- Async reset mid-stall: rstn_i=0 between edges -> outputs go to 0 immediately, instret_o=0, and ready_o=1 after release.
